// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register slice:
// result-select codes, the control bundle struct and the stage FSM states.
package id_ex_stage_pkg;

  localparam logic [2:0] RESULT_SRC_ALU   = 3'b000;
  localparam logic [2:0] RESULT_SRC_MEM   = 3'b001;
  localparam logic [2:0] RESULT_SRC_PC4   = 3'b010;
  localparam logic [2:0] RESULT_SRC_IMM   = 3'b011;
  localparam logic [2:0] RESULT_SRC_AUIPC = 3'b100;

  typedef struct packed {
    logic [2:0] resultSrc;
    logic       aluSrc;
    logic       regWrite;
    logic       memWrite;
  } id_ex_ctrl_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } id_ex_state_t;

  // An empty decode slot must never carry side-effecting control into EX.
  function automatic id_ex_ctrl_t qualifyCtrl(input logic valid, input id_ex_ctrl_t ctrl);
    return valid ? ctrl : '0;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX stage.
// master = decode/execute environment, slave = the pipeline register itself.
interface id_ex_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  iValid;
  logic [2:0]            iResultSrc;
  logic                  iAluSrc;
  logic                  iRegWrite;
  logic                  iMemWrite;
  logic [REG_ADDR_W-1:0] iRs1;
  logic [REG_ADDR_W-1:0] iRs2;
  logic [REG_ADDR_W-1:0] iRd;
  logic                  iUsesRs1;
  logic                  iUsesRs2;
  logic [XLEN-1:0]       iPc;
  logic [XLEN-1:0]       iImm;
  logic [XLEN-1:0]       iRd1;
  logic [XLEN-1:0]       iRd2;
  logic                  iFlush;

  logic                  oStall;
  logic                  oValid;
  logic [2:0]            oResultSrc;
  logic                  oAluSrc;
  logic                  oRegWrite;
  logic                  oMemWrite;
  logic [REG_ADDR_W-1:0] oRs1;
  logic [REG_ADDR_W-1:0] oRs2;
  logic [REG_ADDR_W-1:0] oRd;
  logic [XLEN-1:0]       oPc;
  logic [XLEN-1:0]       oImm;
  logic [XLEN-1:0]       oRd1;
  logic [XLEN-1:0]       oRd2;

  modport master (
    output iValid, iResultSrc, iAluSrc, iRegWrite, iMemWrite,
    output iRs1, iRs2, iRd, iUsesRs1, iUsesRs2,
    output iPc, iImm, iRd1, iRd2, iFlush,
    input  oStall, oValid, oResultSrc, oAluSrc, oRegWrite, oMemWrite,
    input  oRs1, oRs2, oRd, oPc, oImm, oRd1, oRd2
  );

  modport slave (
    input  iValid, iResultSrc, iAluSrc, iRegWrite, iMemWrite,
    input  iRs1, iRs2, iRd, iUsesRs1, iUsesRs2,
    input  iPc, iImm, iRd1, iRd2, iFlush,
    output oStall, oValid, oResultSrc, oAluSrc, oRegWrite, oMemWrite,
    output oRs1, oRs2, oRd, oPc, oImm, oRd1, oRd2
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard flag: a valid load in EX writing a non-zero
// register that the valid decode instruction actually reads.
module load_use_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  exValid,
  input  logic [2:0]            exResultSrc,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  output logic                  hazard
);

  logic exIsLoad;
  logic rs1Match;
  logic rs2Match;

  assign exIsLoad = exValid && (exResultSrc == RESULT_SRC_MEM) && (exRd != '0);
  assign rs1Match = idUsesRs1 && (idRs1 == exRd);
  assign rs2Match = idUsesRs2 && (idRs2 == exRd);
  assign hazard   = exIsLoad && idValid && (rs1Match || rs2Match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion and EX flush.
// Optional performance counters are enabled with `define ID_EX_PERF_CNT_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic        iClk,
  input  logic        iRst,
  id_ex_stage_if.slave idEx
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] oStallCount,
  output logic [31:0] oFlushCount
`endif
);

  id_ex_state_t          stateReg, stateNext;
  logic                  stall;
  logic                  loadBubble;
  logic                  hazard;

  logic                  validReg, validNext;
  id_ex_ctrl_t           ctrlReg, ctrlNext;
  logic [REG_ADDR_W-1:0] rs1Reg, rs1Next;
  logic [REG_ADDR_W-1:0] rs2Reg, rs2Next;
  logic [REG_ADDR_W-1:0] rdReg, rdNext;
  logic [XLEN-1:0]       pcReg, pcNext;
  logic [XLEN-1:0]       immReg, immNext;
  logic [XLEN-1:0]       rd1Reg, rd1Next;
  logic [XLEN-1:0]       rd2Reg, rd2Next;

  id_ex_ctrl_t           ctrlIn;

  assign ctrlIn = '{resultSrc: idEx.iResultSrc,
                    aluSrc:    idEx.iAluSrc,
                    regWrite:  idEx.iRegWrite,
                    memWrite:  idEx.iMemWrite};

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) uLoadUse (
    .exValid    (validReg),
    .exResultSrc(ctrlReg.resultSrc),
    .exRd       (rdReg),
    .idValid    (idEx.iValid),
    .idRs1      (idEx.iRs1),
    .idRs2      (idEx.iRs2),
    .idUsesRs1  (idEx.iUsesRs1),
    .idUsesRs2  (idEx.iUsesRs2),
    .hazard     (hazard)
  );

  // Next-state and stall decision. Flush always wins over a hazard.
  always_comb begin
    stateNext  = stateReg;
    stall      = 1'b0;
    loadBubble = 1'b0;
    unique case (stateReg)
      RUN: begin
        if (idEx.iFlush) begin
          loadBubble = 1'b1;
        end else if (hazard) begin
          stall      = 1'b1;
          loadBubble = 1'b1;
          stateNext  = BUBBLE;
        end
      end
      BUBBLE: begin
        stateNext = RUN;
        if (idEx.iFlush) begin
          loadBubble = 1'b1;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
    if (iRst) begin
      stall = 1'b0;
    end
  end

  always_comb begin
    validNext = idEx.iValid;
    ctrlNext  = qualifyCtrl(idEx.iValid, ctrlIn);
    rs1Next   = idEx.iRs1;
    rs2Next   = idEx.iRs2;
    rdNext    = idEx.iRd;
    pcNext    = idEx.iPc;
    immNext   = idEx.iImm;
    rd1Next   = idEx.iRd1;
    rd2Next   = idEx.iRd2;
    if (loadBubble) begin
      validNext = 1'b0;
      ctrlNext  = '0;
      rs1Next   = '0;
      rs2Next   = '0;
      rdNext    = '0;
      pcNext    = '0;
      immNext   = '0;
      rd1Next   = '0;
      rd2Next   = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg <= RUN;
      validReg <= 1'b0;
      ctrlReg  <= '0;
      rs1Reg   <= '0;
      rs2Reg   <= '0;
      rdReg    <= '0;
      pcReg    <= '0;
      immReg   <= '0;
      rd1Reg   <= '0;
      rd2Reg   <= '0;
    end else begin
      stateReg <= stateNext;
      validReg <= validNext;
      ctrlReg  <= ctrlNext;
      rs1Reg   <= rs1Next;
      rs2Reg   <= rs2Next;
      rdReg    <= rdNext;
      pcReg    <= pcNext;
      immReg   <= immNext;
      rd1Reg   <= rd1Next;
      rd2Reg   <= rd2Next;
    end
  end

  assign idEx.oStall     = stall;
  assign idEx.oValid     = validReg;
  assign idEx.oResultSrc = ctrlReg.resultSrc;
  assign idEx.oAluSrc    = ctrlReg.aluSrc;
  assign idEx.oRegWrite  = ctrlReg.regWrite;
  assign idEx.oMemWrite  = ctrlReg.memWrite;
  assign idEx.oRs1       = rs1Reg;
  assign idEx.oRs2       = rs2Reg;
  assign idEx.oRd        = rdReg;
  assign idEx.oPc        = pcReg;
  assign idEx.oImm       = immReg;
  assign idEx.oRd1       = rd1Reg;
  assign idEx.oRd2       = rd2Reg;

`ifdef ID_EX_PERF_CNT_EN
  // Index 0 counts stall cycles, index 1 counts flush cycles; both saturate.
  logic [1:0]       cntEvent;
  logic [1:0][31:0] cntValue;

  assign cntEvent = {idEx.iFlush, stall};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gPerfCnt
      logic [31:0] cntReg;
      always_ff @(posedge iClk) begin
        if (iRst) begin
          cntReg <= '0;
        end else if (cntEvent[gi] && (cntReg != '1)) begin
          cntReg <= cntReg + 32'd1;
        end
      end
      assign cntValue[gi] = cntReg;
    end
  endgenerate

  assign oStallCount = cntValue[0];
  assign oFlushCount = cntValue[1];
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5)) ifc ();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stallCount, flushCount;
`endif

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .iClk(clk),
    .iRst(rst),
    .idEx(ifc)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .oStallCount(stallCount),
    .oFlushCount(flushCount)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [2:0]  rsrc;
    logic        alu;
    logic        rw;
    logic        mw;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  rsrc;
    logic        alu;
    logic        rw;
    logic        mw;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
  } out_t;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- model ----------------
  out_t expOut = '0;
  int   expStallCnt = 0;
  int   expFlushCnt = 0;

  function automatic bit modelStall();
    bit readsLoad;
    if (rst || ifc.iFlush) return 1'b0;
    readsLoad = (ifc.iUsesRs1 && ifc.iRs1 == expOut.rd) || (ifc.iUsesRs2 && ifc.iRs2 == expOut.rd);
    return expOut.valid && expOut.rsrc == 3'b001 && expOut.rd != 5'd0 && ifc.iValid && readsLoad;
  endfunction

  always @(posedge clk) begin
    bit st;
    st = modelStall();
    if (rst) begin
      expOut      = '0;
      expStallCnt = 0;
      expFlushCnt = 0;
    end else begin
      if (st) expStallCnt++;
      if (ifc.iFlush) expFlushCnt++;
      if (st || ifc.iFlush) begin
        expOut = '0;
      end else begin
        expOut.valid = ifc.iValid;
        expOut.rsrc  = ifc.iValid ? ifc.iResultSrc : 3'b000;
        expOut.alu   = ifc.iValid && ifc.iAluSrc;
        expOut.rw    = ifc.iValid && ifc.iRegWrite;
        expOut.mw    = ifc.iValid && ifc.iMemWrite;
        expOut.rs1   = ifc.iRs1;
        expOut.rs2   = ifc.iRs2;
        expOut.rd    = ifc.iRd;
        expOut.pc    = ifc.iPc;
        expOut.imm   = ifc.iImm;
        expOut.d1    = ifc.iRd1;
        expOut.d2    = ifc.iRd2;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    out_t act;
    if (checkEn) begin
      act = '{ifc.oValid, ifc.oResultSrc, ifc.oAluSrc, ifc.oRegWrite, ifc.oMemWrite,
              ifc.oRs1, ifc.oRs2, ifc.oRd, ifc.oPc, ifc.oImm, ifc.oRd1, ifc.oRd2};
      chk("model_stall", {159'd0, ifc.oStall}, {159'd0, modelStall()});
      chk("model_bundle", {10'd0, act}, {10'd0, expOut});
`ifdef ID_EX_PERF_CNT_EN
      chk("model_stallcnt", {128'd0, stallCount}, 160'(expStallCnt));
      chk("model_flushcnt", {128'd0, flushCount}, 160'(expFlushCnt));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input in_t v);
    ifc.iValid     = v.valid;
    ifc.iResultSrc = v.rsrc;
    ifc.iAluSrc    = v.alu;
    ifc.iRegWrite  = v.rw;
    ifc.iMemWrite  = v.mw;
    ifc.iRs1       = v.rs1;
    ifc.iRs2       = v.rs2;
    ifc.iRd        = v.rd;
    ifc.iUsesRs1   = v.u1;
    ifc.iUsesRs2   = v.u2;
    ifc.iPc        = v.pc;
    ifc.iImm       = v.imm;
    ifc.iRd1       = v.d1;
    ifc.iRd2       = v.d2;
    ifc.iFlush     = v.flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic in_t mkAlu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] pc);
    in_t v = '0;
    v.valid = 1'b1; v.rsrc = RESULT_SRC_ALU; v.rw = 1'b1;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = 1'b1; v.u2 = 1'b1;
    v.pc = pc; v.imm = 32'h10; v.d1 = 32'hA000 + 32'(rs1); v.d2 = 32'hB000 + 32'(rs2);
    return v;
  endfunction

  function automatic in_t mkLoad(input logic [4:0] rd, input logic [31:0] pc);
    in_t v = '0;
    v.valid = 1'b1; v.rsrc = RESULT_SRC_MEM; v.alu = 1'b1; v.rw = 1'b1;
    v.rd = rd; v.rs1 = 5'd1; v.u1 = 1'b1;
    v.pc = pc; v.imm = 32'h4; v.d1 = 32'h1000;
    return v;
  endfunction

  initial begin
    in_t v;
    apply('0);
    rst = 1'b1;
    tick();
    checkEn = 1'b1;
    apply(mkLoad(5'd7, 32'h50));
    #1;
    chk("reset_stall", {159'd0, ifc.oStall}, 160'd0);
    tick();
    chk("reset_valid", {159'd0, ifc.oValid}, 160'd0);
    chk("reset_pc", {128'd0, ifc.oPc}, 160'd0);
    rst = 1'b0;
    apply('0);
    tick();

    // Plain ALU instruction
    apply(mkAlu(5'd5, 5'd1, 5'd2, 32'h100));
    #1;
    chk("alu_stall", {159'd0, ifc.oStall}, 160'd0);
    tick();
    chk("alu_valid", {159'd0, ifc.oValid}, 160'd1);
    chk("alu_rd", {155'd0, ifc.oRd}, 160'd5);
    chk("alu_regwrite", {159'd0, ifc.oRegWrite}, 160'd1);

    // Load x7 then consumer on rs2
    apply(mkLoad(5'd7, 32'h104));
    tick();
    v = mkAlu(5'd8, 5'd3, 5'd7, 32'h108);
    apply(v);
    #1;
    chk("lu_stall", {159'd0, ifc.oStall}, 160'd1);
    tick();
    chk("lu_bubble_valid", {159'd0, ifc.oValid}, 160'd0);
    chk("lu_stall_one_cycle", {159'd0, ifc.oStall}, 160'd0);
    tick();
    chk("lu_capture_valid", {159'd0, ifc.oValid}, 160'd1);
    chk("lu_capture_rs2", {155'd0, ifc.oRs2}, 160'd7);
    chk("lu_capture_pc", {128'd0, ifc.oPc}, 160'h108);

    // Load to x0 never stalls
    apply(mkLoad(5'd0, 32'h10C));
    tick();
    apply(mkAlu(5'd9, 5'd0, 5'd0, 32'h110));
    #1;
    chk("x0_stall", {159'd0, ifc.oStall}, 160'd0);
    tick();

    // rs1 matches but is not used
    apply(mkLoad(5'd7, 32'h114));
    tick();
    v = mkAlu(5'd9, 5'd7, 5'd4, 32'h118);
    v.u1 = 1'b0;
    apply(v);
    #1;
    chk("unused_rs1_stall", {159'd0, ifc.oStall}, 160'd0);
    tick();

    // Hazard and flush together: flush wins
    apply(mkLoad(5'd7, 32'h11C));
    tick();
    v = mkAlu(5'd9, 5'd7, 5'd4, 32'h120);
    v.flush = 1'b1;
    apply(v);
    #1;
    chk("flush_stall", {159'd0, ifc.oStall}, 160'd0);
    tick();
    chk("flush_bubble_valid", {159'd0, ifc.oValid}, 160'd0);
    chk("flush_bubble_rd", {155'd0, ifc.oRd}, 160'd0);
    apply('0);
    tick();

    // Store captured, then reset during a stall
    v = mkAlu(5'd0, 5'd2, 5'd3, 32'h124);
    v.rw = 1'b0; v.mw = 1'b1; v.alu = 1'b1;
    apply(v);
    tick();
    chk("store_memwrite", {159'd0, ifc.oMemWrite}, 160'd1);
    chk("store_alusrc", {159'd0, ifc.oAluSrc}, 160'd1);
    apply(mkLoad(5'd9, 32'h128));
    tick();
    apply(mkAlu(5'd10, 5'd9, 5'd1, 32'h12C));
    #1;
    chk("rststall_pre", {159'd0, ifc.oStall}, 160'd1);
    rst = 1'b1;
    #1;
    chk("rststall_drop", {159'd0, ifc.oStall}, 160'd0);
    tick();
    chk("rststall_valid", {159'd0, ifc.oValid}, 160'd0);
    chk("rststall_pc", {128'd0, ifc.oPc}, 160'd0);
    rst = 1'b0;
    #1;
    chk("rststall_after", {159'd0, ifc.oStall}, 160'd0);
    tick();
    chk("rststall_capture", {155'd0, ifc.oRd}, 160'd10);

    // Invalid decode slot: control forced to zero
    v = mkLoad(5'd6, 32'h200);
    v.valid = 1'b0; v.mw = 1'b1;
    apply(v);
    tick();
    chk("invalid_valid", {159'd0, ifc.oValid}, 160'd0);
    chk("invalid_ctrl", {154'd0, ifc.oResultSrc, ifc.oAluSrc, ifc.oRegWrite, ifc.oMemWrite}, 160'd0);
    // Invalid load in EX cannot cause a stall
    apply(mkAlu(5'd11, 5'd6, 5'd6, 32'h204));
    #1;
    chk("invalid_no_stall", {159'd0, ifc.oStall}, 160'd0);
    tick();

    // Back-to-back dependent loads stall once per pair
    apply(mkLoad(5'd10, 32'h300));
    tick();
    v = mkLoad(5'd11, 32'h304);
    v.rs1 = 5'd10;
    apply(v);
    #1;
    chk("b2b_stall1", {159'd0, ifc.oStall}, 160'd1);
    tick();
    tick();
    apply(mkAlu(5'd12, 5'd11, 5'd0, 32'h308));
    #1;
    chk("b2b_stall2", {159'd0, ifc.oStall}, 160'd1);
    tick();
    tick();

    // Fresh reset, then 3 hazards and 2 flushes for the counters
    rst = 1'b1;
    apply('0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(mkLoad(5'(12 + i), 32'h400 + 32'(i * 16)));
      tick();
      apply(mkAlu(5'd20, 5'(12 + i), 5'd0, 32'h404 + 32'(i * 16)));
      tick();
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      v = mkAlu(5'd21, 5'd1, 5'd2, 32'h500 + 32'(i * 4));
      v.flush = 1'b1;
      apply(v);
      tick();
    end
    apply('0);
    tick();
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall_count", {128'd0, stallCount}, 160'd3);
    chk("perf_flush_count", {128'd0, flushCount}, 160'd2);
`endif
    chk("final_model_stalls", 160'(expStallCnt), 160'd3);
    tick();
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
